// File: rtl/pll_lock_ctrl_pkg.sv
// Shared types and helpers for the PLL lock controller.
package pll_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COARSE = 2'd1,
        FINE   = 2'd2,
        LOCK   = 2'd3
    } ctrl_state_t;

    // Moves code by k toward 0 (neg) or max_code, clamping at either end.
    function automatic logic [31:0] sat_step(input logic [31:0] code,
                                             input logic [31:0] k,
                                             input logic        neg,
                                             input logic [31:0] max_code);
        logic [31:0] r;
        if (neg)
            r = (code > k) ? code - k : '0;
        else
            r = (max_code - code > k) ? code + k : max_code;
        return r;
    endfunction

endpackage

// File: rtl/pfd_err_acc.sv
// Window counter and signed up/down error integrator for the PLL loop filter.
module pfd_err_acc #(
    parameter int WIN_CYC = 256,
    parameter int ERR_W   = $clog2(WIN_CYC) + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    up,
    input  logic                    down,
    output logic signed [ERR_W-1:0] err,
    output logic                    win_last,
    output logic                    clr
);
    localparam int CNT_W = $clog2(WIN_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_CYC - 1);

    logic [CNT_W-1:0]        cnt;
    logic signed [ERR_W-1:0] acc;
    logic signed [ERR_W-1:0] delta;

    always_comb begin
        delta = '0;
        if (up && !down)
            delta = {{(ERR_W-1){1'b0}}, 1'b1};
        else if (down && !up)
            delta = '1;
    end

    // err already includes the current cycle, so on win_last it is the full window total.
    assign err      = acc + delta;
    assign win_last = run && (cnt == LAST);
    assign clr      = !run || win_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            acc <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            acc <= err;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// Coarse/fine acquisition and lock sequencer driving the DCO control word.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int CODE_W        = 10,
    parameter int WIN_CYC       = 256,
    parameter int KP_COARSE     = 16,
    parameter int KP_FINE       = 1,
    parameter int LOCK_THRESH   = 4,
    parameter int LOCK_WINDOWS  = 8,
    parameter int UNLOCK_THRESH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              down,
    input  logic [CODE_W-1:0] code_init,
    output logic [CODE_W-1:0] dco_code,
    output logic              locked,
    output logic [1:0]        state,
    output logic              win_done
);
    localparam int ERR_W  = $clog2(WIN_CYC) + 2;
    localparam int LCNT_W = $clog2(LOCK_WINDOWS + 1);
    localparam logic [ERR_W-1:0]  LOCK_T   = ERR_W'(LOCK_THRESH);
    localparam logic [ERR_W-1:0]  UNLOCK_T = ERR_W'(UNLOCK_THRESH);
    localparam logic [LCNT_W-1:0] LOCK_N   = LCNT_W'(LOCK_WINDOWS);
    localparam logic [31:0]       MAX_CODE = 32'((1 << CODE_W) - 1);

    ctrl_state_t             st;
    logic signed [ERR_W-1:0] err;
    logic                    win_last, clr, run;
    logic [ERR_W-1:0]        mag;
    logic                    neg, big, bad;
    logic [LCNT_W-1:0]       lock_cnt;
    logic                    have_sign, last_neg;
    logic [CODE_W-1:0]       code_fine, code_coarse;

    assign run   = en && (st != IDLE);
    assign state = st;

    pfd_err_acc #(.WIN_CYC(WIN_CYC), .ERR_W(ERR_W)) u_acc (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .up       (up),
        .down     (down),
        .err      (err),
        .win_last (win_last),
        .clr      (clr)
    );

    assign neg = err[ERR_W-1];
    assign mag = neg ? ERR_W'(-err) : ERR_W'(err);
    assign big = mag > LOCK_T;
    assign bad = mag > UNLOCK_T;

    always_comb begin
        code_fine   = dco_code;
        code_coarse = dco_code;
        if (big) begin
            code_fine   = CODE_W'(sat_step(32'(dco_code), 32'(KP_FINE), neg, MAX_CODE));
            code_coarse = CODE_W'(sat_step(32'(dco_code), 32'(KP_COARSE), neg, MAX_CODE));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            dco_code  <= '0;
            locked    <= 1'b0;
            win_done  <= 1'b0;
            lock_cnt  <= '0;
            have_sign <= 1'b0;
            last_neg  <= 1'b0;
        end else if (!en) begin
            st        <= IDLE;
            locked    <= 1'b0;
            win_done  <= 1'b0;
            lock_cnt  <= '0;
            have_sign <= 1'b0;
        end else begin
            win_done <= win_last;
            case (st)
                IDLE: begin
                    dco_code  <= code_init;
                    st        <= COARSE;
                    lock_cnt  <= '0;
                    have_sign <= 1'b0;
                end
                COARSE: if (win_last) begin
                    // A direction reversal means coarse steps overshot: hand over to fine.
                    if (!big || (have_sign && (neg != last_neg))) begin
                        dco_code <= code_fine;
                        st       <= FINE;
                        lock_cnt <= '0;
                    end else begin
                        dco_code  <= code_coarse;
                        have_sign <= 1'b1;
                        last_neg  <= neg;
                    end
                end
                FINE: if (win_last) begin
                    dco_code <= code_fine;
                    if (big) begin
                        lock_cnt <= '0;
                    end else if (lock_cnt + LCNT_W'(1) == LOCK_N) begin
                        lock_cnt <= LOCK_N;
                        st       <= LOCK;
                        locked   <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + LCNT_W'(1);
                    end
                end
                LOCK: if (win_last) begin
                    dco_code <= code_fine;
                    if (bad) begin
                        st       <= FINE;
                        locked   <= 1'b0;
                        lock_cnt <= '0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) win_last |-> clr);

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl against a per-window arithmetic reference model.
module tb_pll_lock_ctrl;
    localparam int CW   = 10;
    localparam int WIN  = 32;
    localparam int KC   = 16;
    localparam int KF   = 1;
    localparam int LT   = 2;
    localparam int LW   = 4;
    localparam int UT   = 8;
    localparam int MAXC = 1023;
    localparam int CYC_LIMIT = 50000;

    logic          clk = 1'b0;
    logic          rst, en, up, down;
    logic [CW-1:0] code_init;
    logic [CW-1:0] dco_code;
    logic          locked, win_done;
    logic [1:0]    state;

    typedef struct {
        int    due;
        int    code;
        int    st;
        bit    lk;
        bit    wd;
        string name;
    } exp_t;

    exp_t now_q[$];
    exp_t win_q[$];

    int cyc = 0;
    bit done = 1'b0;
    int n_pass = 0;
    int n_tot = 0;

    int m_code, m_state, m_lock_cnt, m_sign;
    bit m_locked;

    pll_lock_ctrl #(
        .CODE_W        (CW),
        .WIN_CYC       (WIN),
        .KP_COARSE     (KC),
        .KP_FINE       (KF),
        .LOCK_THRESH   (LT),
        .LOCK_WINDOWS  (LW),
        .UNLOCK_THRESH (UT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .down      (down),
        .code_init (code_init),
        .dco_code  (dco_code),
        .locked    (locked),
        .state     (state),
        .win_done  (win_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic int sat(input int x);
        return (x < 0) ? 0 : ((x > MAXC) ? MAXC : x);
    endfunction

    task automatic model_window(input int err);
        int mag, sg, stp;
        mag = (err < 0) ? -err : err;
        sg  = (err > 0) ? 1 : -1;
        stp = (mag > LT) ? sg : 0;
        case (m_state)
            1: begin
                if (mag <= LT || (m_sign != 0 && sg != m_sign)) begin
                    m_code = sat(m_code + stp * KF);
                    m_state = 2;
                    m_lock_cnt = 0;
                end else begin
                    m_code = sat(m_code + stp * KC);
                    m_sign = sg;
                end
            end
            2: begin
                m_code = sat(m_code + stp * KF);
                m_lock_cnt = (mag <= LT) ? m_lock_cnt + 1 : 0;
                if (m_lock_cnt == LW) begin
                    m_state = 3;
                    m_locked = 1'b1;
                end
            end
            3: begin
                m_code = sat(m_code + stp * KF);
                if (mag > UT) begin
                    m_state = 2;
                    m_locked = 1'b0;
                    m_lock_cnt = 0;
                end
            end
            default: ;
        endcase
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic expect_now(input string name, input int due_off);
        exp_t e;
        e.due = cyc + due_off; e.code = m_code; e.st = m_state;
        e.lk = m_locked; e.wd = 1'b0; e.name = name;
        now_q.push_back(e);
    endtask

    task automatic check(input exp_t e);
        n_tot++;
        if (int'(dco_code) == e.code && int'(state) == e.st && locked == e.lk && win_done == e.wd)
            n_pass++;
        else
            $display("FAIL %s @cyc %0d: got code=%0d state=%0d locked=%0b win_done=%0b, need code=%0d state=%0d locked=%0b win_done=%0b",
                     e.name, cyc, dco_code, state, locked, win_done, e.code, e.st, e.lk, e.wd);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        while (now_q.size() > 0 && now_q[0].due <= cyc) begin
            e = now_q.pop_front();
            check(e);
        end
        if (win_done === 1'b1) begin
            if (win_q.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_win_done @cyc %0d: got win_done=1 code=%0d state=%0d, need no window end", cyc, dco_code, state);
            end else begin
                e = win_q.pop_front();
                check(e);
            end
        end
        if (done || cyc > CYC_LIMIT) begin
            n_tot++;
            if (!done)
                $display("FAIL timeout: ran %0d cycles, limit %0d", cyc, CYC_LIMIT);
            else if (win_q.size() != 0 || now_q.size() != 0)
                $display("FAIL pending: got %0d window and %0d immediate expectations outstanding, need 0", win_q.size(), now_q.size());
            else
                n_pass++;
            $display("%0d/%0d checks passed", n_pass, n_tot);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic start(input int ci);
        code_init = CW'(ci);
        en = 1'b1;
        m_code = ci; m_state = 1; m_locked = 1'b0; m_lock_cnt = 0; m_sign = 0;
        expect_now("enable", 1);
        @(posedge clk); #1;
    endtask

    task automatic window(input logic [31:0] u, input logic [31:0] d, input string name);
        int   err;
        exp_t e;
        err = 0;
        for (int i = 0; i < WIN; i++) begin
            if (u[i] && !d[i]) err++;
            else if (d[i] && !u[i]) err--;
        end
        model_window(err);
        e.due = -1; e.code = m_code; e.st = m_state;
        e.lk = m_locked; e.wd = 1'b1; e.name = name;
        win_q.push_back(e);
        for (int i = 0; i < WIN; i++) begin
            up = u[i]; down = d[i];
            @(posedge clk); #1;
        end
        up = 1'b0; down = 1'b0;
    endtask

    task automatic drop_en(input int n);
        for (int i = 0; i < n; i++) begin
            up = 1'($urandom); down = 1'($urandom);
            @(posedge clk); #1;
        end
        en = 1'b0;
        m_state = 0; m_locked = 1'b0;
        expect_now("en_drop", 1);
        @(posedge clk); #1;
        code_init = CW'($urandom);
        expect_now("idle_hold", 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] u, d;
        rst = 1'b1; en = 1'b1; up = 1'b0; down = 1'b0; code_init = CW'(777);
        repeat (3) @(posedge clk);
        #1;
        m_code = 0; m_state = 0; m_locked = 1'b0;
        expect_now("reset", 0);
        rst = 1'b0; en = 1'b0;
        @(posedge clk); #1;

        start(512);
        window('1, '0, "coarse_w1");
        window('1, '0, "coarse_w2");
        drop_en(10);

        start(512);
        window('1, '0, "coarse_up");
        window('0, '1, "sign_flip");
        repeat (4) window('0, '0, "fine_quiet");
        window(32'h0000_0FFF, '0, "unlock12");
        window('1, '1, "both_high");
        drop_en(10);

        start(1020);
        repeat (3) window('1, '0, "sat_high");
        drop_en(5);

        start(3);
        repeat (2) window('0, '1, "sat_low");
        drop_en(31);

        start(300);
        repeat (5) window('0, '0, "to_lock");
        for (int i = 0; i < 7; i++) begin
            up = 1'($urandom); down = 1'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        m_code = 0; m_state = 0; m_locked = 1'b0;
        expect_now("rst_in_lock", 1);
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b0;
        @(posedge clk); #1;

        repeat (6) begin
            start(int'($urandom_range(0, MAXC)));
            repeat ($urandom_range(4, 12)) begin
                case ($urandom_range(0, 3))
                    0: begin u = $urandom; d = $urandom; end
                    1: begin u = $urandom | $urandom; d = $urandom & $urandom; end
                    2: begin u = $urandom & $urandom; d = $urandom | $urandom; end
                    default: begin
                        u = $urandom & $urandom & $urandom & $urandom;
                        d = $urandom & $urandom & $urandom & $urandom;
                    end
                endcase
                window(u, d, "random");
            end
            drop_en(int'($urandom_range(0, 31)));
        end

        done = 1'b1;
        repeat (10) @(posedge clk);
        $display("FAIL no_finish: monitor did not close the run");
        $fatal(1);
    end

endmodule
